// File: rtl/led_zone_serializer_if.sv
// Zone-vector handshake plus FIFO write-side signals for the LED zone serializer.
//   zone_data  : ZONES*DW brightness vector, zone k at [k*DW +: DW]
//   zone_valid : producer has a vector to hand over
//   zone_ready : serializer can accept a vector
//   full       : FIFO full flag (write clock domain)
//   wr_en      : FIFO write strobe
//   din        : FIFO write data
// master = producer/FIFO side, slave = serializer.
interface led_zone_serializer_if #(
    parameter int ZONES = 40,
    parameter int DW    = 8
);
    logic [ZONES*DW-1:0] zone_data;
    logic                zone_valid;
    logic                zone_ready;
    logic                full;
    logic                wr_en;
    logic [DW-1:0]       din;

    modport master (
        output zone_data, zone_valid, full,
        input  zone_ready, wr_en, din
    );

    modport slave (
        input  zone_data, zone_valid, full,
        output zone_ready, wr_en, din
    );
endinterface

// File: rtl/led_zone_serializer.sv
// Writer side of the zone-brightness FIFO link. Accepts one ZONES x DW
// brightness vector per frame, snapshots it, then writes an optional header
// byte followed by zone 0..ZONES-1 into the LED driver FIFO, stalling on full.
// Ports:
//   wr_clk     : FIFO write clock, all logic on rising edge
//   rst        : synchronous active-high reset
//   bus        : zone handshake + FIFO write signals (slave modport)
//   busy       : frame in progress (state other than IDLE)
//   frame_done : one-cycle pulse after the last byte of a frame
//   byte_idx   : index of the next zone byte to write
//   frame_cnt  : completed frame counter, wraps
//
// state | meaning
// IDLE  | waiting for a zone vector handshake
// HDR   | writing the header byte
// DATA  | writing zone bytes, byte_idx selects the zone
// DONE  | frame complete, pulse frame_done and bump frame_cnt
module led_zone_serializer #(
    parameter int             ZONES    = 40,
    parameter int             DW       = 8,
    parameter bit             HDR_EN   = 1'b1,
    parameter logic [DW-1:0]  HDR_BYTE = 8'hA5
) (
    input  logic                        wr_clk,
    input  logic                        rst,
    led_zone_serializer_if.slave        bus,
    output logic                        busy,
    output logic                        frame_done,
    output logic [5:0]                  byte_idx,
    output logic [15:0]                 frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

    localparam logic [5:0] LAST_IDX = 6'(ZONES - 1);

    state_t              state, state_nxt;
    logic [ZONES*DW-1:0] shadow;
    logic [5:0]          idx_q, idx_nxt;
    logic [15:0]         frame_cnt_q;
    logic                load;

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state       <= S_IDLE;
            shadow      <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            idx_q <= idx_nxt;
            if (load)
                shadow <= bus.zone_data;
            if (state == S_DONE)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx_q;
        load           = 1'b0;
        bus.zone_ready = 1'b0;
        bus.wr_en      = 1'b0;
        bus.din        = '0;
        frame_done     = 1'b0;

        case (state)
            S_IDLE: begin
                bus.zone_ready = !rst;
                if (bus.zone_valid && !rst) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = HDR_EN ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                if (!bus.full) begin
                    bus.wr_en = 1'b1;
                    bus.din   = HDR_BYTE;
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (!bus.full) begin
                    bus.wr_en = 1'b1;
                    bus.din   = shadow[int'(idx_q)*DW +: DW];
                    if (idx_q == LAST_IDX)
                        state_nxt = S_DONE;
                    else
                        idx_nxt = idx_q + 6'd1;
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                idx_nxt    = '0;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // A reset cycle must never push a byte or signal completion,
        // even when it lands in the middle of a frame.
        if (rst) begin
            bus.wr_en  = 1'b0;
            bus.din    = '0;
            frame_done = 1'b0;
        end
    end

    assign busy      = (state != S_IDLE);
    assign byte_idx  = idx_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_led_zone_serializer.sv
module tb_led_zone_serializer;

    localparam int ZONES = 40;
    localparam int DW    = 8;
    localparam int ZW    = ZONES * DW;

    logic        wr_clk = 1'b0;
    logic        rst;
    logic        busy, frame_done;
    logic [5:0]  byte_idx;
    logic [15:0] frame_cnt;
    logic        busy0, frame_done0;
    logic [5:0]  byte_idx0;
    logic [15:0] frame_cnt0;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt_model = 16'd0;

    always #5 wr_clk = ~wr_clk;

    led_zone_serializer_if #(.ZONES(ZONES), .DW(DW)) zi ();
    led_zone_serializer_if #(.ZONES(ZONES), .DW(DW)) zi0 ();

    led_zone_serializer #(.ZONES(ZONES), .DW(DW), .HDR_EN(1'b1), .HDR_BYTE(8'hA5)) dut (
        .wr_clk(wr_clk), .rst(rst), .bus(zi.slave),
        .busy(busy), .frame_done(frame_done), .byte_idx(byte_idx), .frame_cnt(frame_cnt)
    );

    led_zone_serializer #(.ZONES(ZONES), .DW(DW), .HDR_EN(1'b0), .HDR_BYTE(8'hA5)) dut0 (
        .wr_clk(wr_clk), .rst(rst), .bus(zi0.slave),
        .busy(busy0), .frame_done(frame_done0), .byte_idx(byte_idx0), .frame_cnt(frame_cnt0)
    );

    typedef struct {
        bit ramp;
        int pre;
        int mid_idx;
        int mid_len;
        bit rnd;
        int exp_done;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ZW-1:0] mk_ramp();
        logic [ZW-1:0] v;
        for (int k = 0; k < ZONES; k++) v[k*DW +: DW] = 8'(k + 1);
        return v;
    endfunction

    function automatic logic [ZW-1:0] mk_rand();
        logic [ZW-1:0] v;
        for (int k = 0; k < ZONES; k++) v[k*DW +: DW] = 8'($urandom);
        return v;
    endfunction

    // Called between a negedge and the next posedge with the DUT idle.
    // Returns at the negedge of the cycle after DONE.
    task automatic send_frame(input logic [ZW-1:0] data, input int pre, input int mid_idx,
                              input int mid_len, input bit rnd, input int exp_done,
                              input bit hold_valid, input logic [ZW-1:0] after_data);
        logic [7:0] exp_q[$];
        int n, stalls, done_c, mid_rem, want;
        bit f;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < ZONES; k++) exp_q.push_back(data[k*DW +: DW]);
        chk("ready_idle", zi.zone_ready, 1);
        zi.zone_valid = 1'b1;
        zi.zone_data  = data;
        @(posedge wr_clk); #1;
        zi.zone_valid = hold_valid;
        zi.zone_data  = after_data;
        n = 0; stalls = 0; done_c = -1; mid_rem = mid_len;
        for (int c = 1; c <= 400; c++) begin
            f = 1'b0;
            if (n == 0 && c <= pre) f = 1'b1;
            if (n == 1 + mid_idx && mid_rem > 0) begin
                f = 1'b1;
                mid_rem--;
            end
            if (rnd && $urandom_range(0, 3) == 0) f = 1'b1;
            if (f && n < exp_q.size()) stalls++;
            zi.full = f;
            @(negedge wr_clk);
            if (c == 1) begin
                chk("busy_in_frame", busy, 1);
                chk("ready_low_in_frame", zi.zone_ready, 0);
            end
            if (zi.wr_en) begin
                chk("no_write_when_full", zi.full, 0);
                if (n < exp_q.size())
                    chk("byte_value", zi.din, exp_q[n]);
                else begin
                    checks++; errors++;
                    $display("FAIL extra_write: got %0h expected no write", zi.din);
                end
                n++;
            end
            if (frame_done) begin
                done_c = c;
                break;
            end
            @(posedge wr_clk); #1;
        end
        zi.full = 1'b0;
        if (done_c < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no frame_done expected within 400 cycles");
            @(negedge wr_clk);
        end
        want = (exp_done >= 0) ? exp_done : exp_q.size() + 1 + stalls;
        chk("write_count", n, exp_q.size());
        chk("done_cycle", done_c, want);
        cnt_model = cnt_model + 16'd1;
        @(posedge wr_clk); #1;
        @(negedge wr_clk);
        chk("frame_cnt", frame_cnt, cnt_model);
        chk("ready_after_frame", zi.zone_ready, 1);
        chk("busy_after_frame", busy, 0);
        chk("done_single_pulse", frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, writes, first_c, done_c, ready_c;

        vecs[0] = '{ramp: 1'b1, pre: 0, mid_idx: 0,  mid_len: 0, rnd: 1'b0, exp_done: 42};
        vecs[1] = '{ramp: 1'b1, pre: 3, mid_idx: 10, mid_len: 2, rnd: 1'b0, exp_done: 47};
        vecs[2] = '{ramp: 1'b0, pre: 0, mid_idx: 0,  mid_len: 4, rnd: 1'b0, exp_done: 46};
        vecs[3] = '{ramp: 1'b0, pre: 1, mid_idx: 39, mid_len: 3, rnd: 1'b0, exp_done: 46};

        rst = 1'b1;
        zi.zone_valid = 1'b0; zi.zone_data = '0; zi.full = 1'b0;
        zi0.zone_valid = 1'b0; zi0.zone_data = '0; zi0.full = 1'b0;
        @(negedge wr_clk);
        chk("rst_ready", zi.zone_ready, 0);
        chk("rst_wr_en", zi.wr_en, 0);
        chk("rst_din", zi.din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_idx", byte_idx, 0);
        chk("rst_cnt", frame_cnt, 0);
        @(posedge wr_clk); #1;
        @(posedge wr_clk); #1;
        rst = 1'b0;
        @(negedge wr_clk);

        for (int i = 0; i < 4; i++)
            send_frame(vecs[i].ramp ? mk_ramp() : mk_rand(), vecs[i].pre, vecs[i].mid_idx,
                       vecs[i].mid_len, vecs[i].rnd, vecs[i].exp_done, 1'b0, mk_rand());

        for (int i = 0; i < 8; i++)
            send_frame(mk_rand(), 0, 0, 0, 1'b1, -1, 1'b0, mk_rand());

        // Snapshot: data changes to all FF right after the handshake and valid stays high.
        send_frame(mk_ramp(), 0, 0, 0, 1'b0, 42, 1'b1, {ZONES{8'hFF}});
        send_frame({ZONES{8'hFF}}, 0, 0, 0, 1'b0, 42, 1'b0, mk_rand());

        // Reset in the middle of a frame.
        zi.zone_valid = 1'b1;
        zi.zone_data  = mk_ramp();
        @(posedge wr_clk); #1;
        zi.zone_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge wr_clk);
            if (byte_idx == 6'd20) begin
                seen = 1;
                break;
            end
            @(posedge wr_clk); #1;
        end
        chk("reached_idx20", seen, 1);
        rst = 1'b1;
        #1;
        chk("rst_cycle_wr_en", zi.wr_en, 0);
        chk("rst_cycle_done", frame_done, 0);
        @(posedge wr_clk); #1;
        rst = 1'b0;
        cnt_model = 16'd0;
        @(negedge wr_clk);
        chk("post_rst_ready", zi.zone_ready, 1);
        chk("post_rst_idx", byte_idx, 0);
        chk("post_rst_cnt", frame_cnt, 0);
        chk("post_rst_busy", busy, 0);
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_no_write", zi.wr_en, 0);
            chk("post_rst_no_done", frame_done, 0);
            @(posedge wr_clk); #1;
            @(negedge wr_clk);
        end
        send_frame(mk_ramp(), 0, 0, 0, 1'b0, 42, 1'b0, mk_rand());

        // Counter wrap from a preloaded FFFF.
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge wr_clk); #1;
        release dut.frame_cnt_q;
        @(negedge wr_clk);
        chk("preload_cnt", frame_cnt, 16'hFFFF);
        cnt_model = 16'hFFFF;
        send_frame(mk_rand(), 0, 0, 0, 1'b0, 42, 1'b0, mk_rand());
        chk("wrap_cnt", frame_cnt, 0);

        // Header-disabled instance.
        zi0.zone_data  = {ZONES{8'h5A}};
        zi0.zone_valid = 1'b1;
        chk("nohdr_ready", zi0.zone_ready, 1);
        @(posedge wr_clk); #1;
        zi0.zone_valid = 1'b0;
        zi0.zone_data  = '0;
        writes = 0; first_c = -1; done_c = -1; ready_c = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge wr_clk);
            if (zi0.wr_en) begin
                if (first_c < 0) first_c = c;
                chk("nohdr_byte", zi0.din, 8'h5A);
                writes++;
            end
            if (frame_done0) done_c = c;
            if (zi0.zone_ready) begin
                ready_c = c;
                break;
            end
            @(posedge wr_clk); #1;
        end
        chk("nohdr_first_write", first_c, 1);
        chk("nohdr_writes", writes, 40);
        chk("nohdr_done", done_c, 41);
        chk("nohdr_period", ready_c, 42);
        chk("nohdr_cnt", frame_cnt0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_zone_serializer.md
# led_zone_serializer

Writer side of the zone-brightness FIFO link in the local-dimming LED path. It accepts one 40-zone × 8-bit brightness vector per frame through a valid/ready handshake and snapshots it. It then writes an optional header byte followed by the 40 zone bytes, zone 0 first, into the FIFO feeding the LED driver. It honours FIFO `full` back-pressure on every byte.

## Interface
- `ZONES`, 40, number of zones (bytes) per frame; 2..63.
- `DW`, 8, bits per zone / FIFO word width.
- `HDR_EN`, 1, 1 = write `HDR_BYTE` before zone 0; 0 = no header.
- `HDR_BYTE`, 8'hA5, header value.

Ports:
- `wr_clk`  in  1  FIFO write clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `zone_data`  in  ZONES*DW  brightness vector; zone k at `[k*DW +: DW]`.
- `zone_valid`  in  1  `zone_data` is valid.
- `zone_ready`  out  1  block can accept a vector; transfer when `zone_valid && zone_ready`.
- `full`  in  1  FIFO full flag, same clock domain.
- `wr_en`  out  1  FIFO write strobe.
- `din`  out  DW  FIFO write data.
- `busy`  out  1  frame in progress (any state other than IDLE).
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame is written.
- `byte_idx`  out  6  index of the next zone byte to write.
- `frame_cnt`  out  16  completed frames; wraps 16'hFFFF -> 0.

## Operation
- FSM states: IDLE, HDR, DATA, DONE. Reset and `rst` force IDLE.
- IDLE:
  - `zone_ready = !rst`.
  - On handshake: latch `zone_data` into the internal shadow register, set `byte_idx = 0`, and go to HDR if `HDR_EN`, else to DATA.
  - Without a handshake, stay in IDLE.
- HDR:
  - `wr_en = !full`, `din = HDR_BYTE`.
  - If `!full`, go to DATA. Otherwise hold.
- DATA:
  - `wr_en = !full`, `din = shadow[byte_idx*DW +: DW]`.
  - If `!full` and `byte_idx == ZONES-1`, go to DONE.
  - If `!full` and `byte_idx` is any other value, increment `byte_idx`.
  - If `full`, hold (index and state unchanged).
- DONE:
  - `frame_done = 1` and `frame_cnt` increments.
  - `byte_idx` clears to 0.
  - Next state is IDLE, unconditionally.
- Output decoding: `wr_en` and `din` are combinational from state, index, shadow and `full`. `din = 0` whenever `wr_en = 0`.
- `zone_ready` is 0 in HDR, DATA and DONE. `zone_valid` is ignored there, and `zone_data` may change freely once accepted.
- `wr_en` is never 1 while `full` is 1; no FIFO overflow is possible.
- `full` may toggle on any cycle. Each stall only delays the frame; no byte is duplicated or skipped.
- `rst` mid-frame:
  - Next cycle is IDLE with `byte_idx = 0`; `frame_cnt` and the shadow register are cleared.
  - The partial frame is abandoned and `frame_done` is not pulsed.
  - `wr_en` is 0 in the reset cycle itself.
- Reset values: `zone_ready = 0` (while `rst` is high), `wr_en = 0`, `din = 0`, `busy = 0`, `frame_done = 0`, `byte_idx = 0`, `frame_cnt = 0`.

## Timing
- Handshake at edge T (state IDLE -> HDR). With no back-pressure:
  - Header is written in cycle T+1.
  - Zone k is written in cycle T+2+k; zone 39 in T+41.
  - DONE occurs in T+42 (`frame_done` = 1).
  - IDLE in T+43, `zone_ready` = 1; the earliest next handshake is at edge T+43.
- Frame period with defaults: 43 cycles. With `HDR_EN = 0`: 42 cycles (zone k written at T+1+k).
- Each cycle with `full = 1` while in HDR or DATA adds exactly one cycle of latency.
- `busy` = 1 from cycle T+1 through the DONE cycle inclusive.
- `frame_cnt` shows its new value in the cycle after DONE.

## Test plan
- **Basic frame:** `zone_data` zone k = k+1, `HDR_EN = 1`, `full = 0`. Expect 41 consecutive `wr_en` cycles with `din` = A5, 01, 02, …, 28 (hex). Then `frame_done` pulses once, `frame_cnt` = 1, and `zone_ready` returns after 43 cycles total.
- **Back-pressure:**
  - Assert `full` for 3 cycles before the header and for 2 cycles while `byte_idx = 10`.
  - Expect `wr_en` = 0 whenever `full` = 1.
  - Expect the byte sequence unchanged and no duplicates.
  - Expect `frame_done` 5 cycles later than in the basic case.
- **Snapshot:** change `zone_data` to all FF one cycle after the handshake. The written bytes must still be 01..28. A `zone_valid` held high during the frame must be ignored, and the next frame must then send all FF.
- **Header disabled:** `HDR_EN = 0`, zones all 0x5A. Expect exactly 40 writes of 5A, `frame_done` at T+41, and period 42.
- **Reset mid-frame:**
  - Assert `rst` for 1 cycle when `byte_idx = 20`.
  - Expect no `wr_en` in the reset cycle or after it.
  - Expect `frame_done` never pulsed, `byte_idx` = 0, `frame_cnt` = 0, and `zone_ready` = 1 the cycle after `rst` falls.
  - A new frame must then start correctly with header A5.
- **Counter wrap:** preload by running 65536 frames (or force `frame_cnt` = FFFF). After one more frame, expect `frame_cnt` = 0.
